sink: RTL and testbench

SINK -- requirements
Module: sink

---
 rtl/sink_pkg.sv | 12 +
 rtl/sink.sv | 69 ++++++
 tb/tb_sink.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sink_pkg.sv
// Shared helpers for the message sink: error-count type and saturating increment.
package sink_pkg;

   localparam int unsigned err_width = 32;

   typedef logic [err_width-1:0] err_count_t;

   function automatic err_count_t sat_inc(input err_count_t c);
      return (c == '1) ? c : c + err_count_t'(1);
   endfunction

endpackage

// File: rtl/sink.sv
// Test sink: accepts p_nmsgs messages on a val/rdy port and checks each against
// the preloaded expectation array mem, counting and reporting mismatches.
module sink
   import sink_pkg::*;
#(
   parameter int unsigned p_width = 16,
   parameter int unsigned p_nmsgs = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               val,
   output logic               rdy,
   input  logic [p_width-1:0] msg,
   output logic               done
);

   localparam int unsigned idx_width = $clog2(p_nmsgs + 1);
   localparam int unsigned mem_aw    = (p_nmsgs > 1) ? $clog2(p_nmsgs) : 1;
   localparam logic [idx_width-1:0] last_idx = idx_width'(p_nmsgs - 1);

   // Expected messages; loaded by the bench through hierarchical reference.
   logic [p_width-1:0] mem [p_nmsgs];

   logic [idx_width-1:0] idx;
   logic [mem_aw-1:0]    mem_idx;
   err_count_t           num_errors;
   err_count_t           num_errors_d;
   logic                 xfer;
   logic                 mismatch;

   assign done     = (idx == idx_width'(p_nmsgs));
   assign rdy      = !reset && !done;
   assign xfer     = val && rdy;
   assign mem_idx  = idx[mem_aw-1:0];
   // 4-state compare so X/Z on msg is flagged rather than silently matching.
   assign mismatch = (msg !== mem[mem_idx]);

   always_comb begin
      num_errors_d = num_errors;
      if (xfer && mismatch) begin
         num_errors_d = sat_inc(num_errors);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= '0;
         num_errors <= '0;
      end else if (xfer) begin
         idx        <= idx + idx_width'(1);
         num_errors <= num_errors_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (xfer) begin
         if (mismatch) begin
            $display("%0t: ERROR: sink msg %0d expected %h got %h",
                     $time, idx, mem[mem_idx], msg);
         end
         if (idx == last_idx) begin
            $display("%0t: Sink done: %0d msgs, %0d errors", $time, p_nmsgs, num_errors_d);
         end
      end
   end
`endif

endmodule

// File: tb/tb_sink.sv
// Randomized and directed self-checking bench for sink against a queue-free
// reference model computed from the transfer rules.
module tb_sink;

   localparam int unsigned n = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        val = 1'b0;
   logic [15:0] msg = '0;
   logic        rdy;
   logic        done;

   logic        reset1 = 1'b1;
   logic        val1 = 1'b0;
   logic [15:0] msg1 = '0;
   logic        rdy1;
   logic        done1;

   int          n_checks = 0;
   int          n_fails  = 0;

   // Reference model state
   logic [15:0] exp_mem [n];
   int          m_idx = 0;
   int          m_err = 0;

   always #5 clk = ~clk;

   sink #(.p_width(16), .p_nmsgs(n)) dut (
      .clk   (clk),
      .reset (reset),
      .val   (val),
      .rdy   (rdy),
      .msg   (msg),
      .done  (done)
   );

   sink #(.p_width(16), .p_nmsgs(1)) dut1 (
      .clk   (clk),
      .reset (reset1),
      .val   (val1),
      .rdy   (rdy1),
      .msg   (msg1),
      .done  (done1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
      exp_mem[0] = a; exp_mem[1] = b; exp_mem[2] = c; exp_mem[3] = d;
      for (int i = 0; i < n; i++) dut.mem[i] = exp_mem[i];
   endtask

   // One clock: drive inputs mid-period, check combinational outputs, then state after the edge.
   task automatic step(input logic r, input logic v, input logic [15:0] m);
      logic xfer;
      @(negedge clk);
      reset = r; val = v; msg = m;
      #1;
      check("rdy", rdy, (!r && m_idx < n));
      check("done", done, m_idx == n);
      xfer = v && !r && (m_idx < n);
      @(posedge clk);
      #1;
      if (r) begin
         m_idx = 0;
         m_err = 0;
      end else if (xfer) begin
         if (m !== exp_mem[m_idx]) m_err++;
         m_idx++;
      end
      check("idx", dut.idx, m_idx);
      check("num_errors", dut.num_errors, m_err);
   endtask

   task automatic send4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
      step(1'b0, 1'b1, a);
      step(1'b0, 1'b1, b);
      step(1'b0, 1'b1, c);
      step(1'b0, 1'b1, d);
   endtask

   initial begin
      // Single-message instance: FFFF accepted in one transfer.
      dut1.mem[0] = 16'hFFFF;
      load(16'd5, 16'd2, 16'd18, 16'd3);
      @(negedge clk);
      reset1 = 1'b0; val1 = 1'b1; msg1 = 16'hFFFF;
      #1;
      check("dut1 rdy", rdy1, 1'b1);
      check("dut1 done before", done1, 1'b0);
      @(posedge clk);
      #1;
      check("dut1 done after", done1, 1'b1);
      check("dut1 rdy after", rdy1, 1'b0);
      check("dut1 errors", dut1.num_errors, 0);
      val1 = 1'b0;

      // Clean run, then val held after done.
      step(1'b1, 1'b1, 16'd0);
      step(1'b1, 1'b0, 16'd0);
      send4(16'd5, 16'd2, 16'd18, 16'd3);
      step(1'b0, 1'b1, 16'd3);
      step(1'b0, 1'b1, 16'd7);

      // Two-cycle val gap between messages 2 and 3.
      step(1'b1, 1'b0, 16'd0);
      step(1'b0, 1'b1, 16'd5);
      step(1'b0, 1'b1, 16'd2);
      step(1'b0, 1'b0, 16'd18);
      step(1'b0, 1'b0, 16'd18);
      step(1'b0, 1'b1, 16'd18);
      step(1'b0, 1'b1, 16'd3);
      step(1'b0, 1'b0, 16'd0);

      // One corrupted message.
      step(1'b1, 1'b0, 16'd0);
      send4(16'd5, 16'd2, 16'd19, 16'd3);
      step(1'b0, 1'b0, 16'd0);

      // Reset after two transfers, then a full clean resend.
      step(1'b1, 1'b0, 16'd0);
      step(1'b0, 1'b1, 16'd5);
      step(1'b0, 1'b1, 16'd2);
      step(1'b1, 1'b1, 16'd18);
      send4(16'd5, 16'd2, 16'd18, 16'd3);
      step(1'b0, 1'b0, 16'd0);

      // Randomized rounds with fresh expectations, val bubbles, rare bad data and resets.
      for (int round = 0; round < 20; round++) begin
         step(1'b1, 1'b0, 16'd0);
         load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         step(1'b1, 1'b1, 16'($urandom));
         for (int k = 0; k < 12; k++) begin
            logic        r;
            logic        v;
            logic [15:0] m;
            r = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            m = (m_idx < n) ? exp_mem[m_idx] : 16'($urandom);
            if ($urandom_range(0, 9) == 0) m = m ^ 16'($urandom_range(1, 65535));
            step(r, v, m);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
